// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core scheduler.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } aes_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CRST  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

  // Reserved key-size encodings are rejected without touching the core.
  function automatic logic mode_is_rsvd(input aes_mode_t m);
    return (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               any
);

  // Scan requesters starting at ptr; first hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    int            sum;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PW'(sum);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/aes_core_sched.sv
// Time-shares one AES core between NUM_REQ requesters. Each job is
// captured at grant, then sequenced: core reset, start, wait for done
// (or timeout), and a held response to the owning requester.
module aes_core_sched
  import aes_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RST_CYCLES   = 2,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_enc_dec,
  input  logic [2*NUM_REQ-1:0]   req_mode,
  input  logic [256*NUM_REQ-1:0] req_key,
  input  logic [128*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   core_reset,
  output logic                   core_start,
  output logic                   core_enc_dec,
  output logic [1:0]             core_mode,
  output logic [255:0]           core_key,
  output logic [127:0]           core_data_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  // Per-requester views of the flat request buses.
  logic [NUM_REQ-1:0][1:0]           mode_arr;
  logic [NUM_REQ-1:0][AES_KEY_W-1:0] key_arr;
  logic [NUM_REQ-1:0][AES_BLK_W-1:0] data_arr;

  assign mode_arr = req_mode;
  assign key_arr  = req_key;
  assign data_arr = req_data;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  sched_state_t         state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic                 enc_q, enc_d;
  aes_mode_t            mode_q, mode_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Job sequencing: grant/capture, core reset, start, wait, respond.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    enc_d      = enc_q;
    mode_d     = mode_q;
    key_d      = key_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d    = arb_idx;
          enc_d      = req_enc_dec[arb_idx];
          mode_d     = aes_mode_t'(mode_arr[arb_idx]);
          key_d      = key_arr[arb_idx];
          data_d     = data_arr[arb_idx];
          rr_ptr_d   = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d      = '0;
          rsp_data_d = '0;
          if (mode_is_rsvd(aes_mode_t'(mode_arr[arb_idx]))) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = CRST;
          end
        end
      end
      CRST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (core_done) begin
          rsp_data_d = core_data_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and job registers; reset drops any in-flight job silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      enc_q      <= 1'b0;
      mode_q     <= MODE_128;
      key_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      enc_q      <= enc_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Response valid is steered to the job owner only.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  // Accept is only offered from IDLE and never while reset is applied.
  assign req_ready    = (state_q == IDLE && reset) ? arb_grant : '0;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state_q != IDLE);
  assign core_reset   = !reset || (state_q == CRST);
  assign core_start   = (state_q == START);
  assign core_enc_dec = enc_q;
  assign core_mode    = mode_q;
  assign core_key     = key_q;
  assign core_data_in = data_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a lookup-table core model
// answering the known SP800-38A AES-128/256 single-block vectors.
module tb_aes_core_sched;

  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 1024;
  localparam int MAX_WAIT = 3000;

  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C256 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] C128 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] BAD  = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid, req_ready, req_enc_dec;
  logic [2*NUM_REQ-1:0]   req_mode;
  logic [256*NUM_REQ-1:0] req_key;
  logic [128*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]     rsp_valid, rsp_ready;
  logic [127:0]           rsp_data;
  logic                   rsp_err, busy;
  logic                   core_reset, core_start, core_enc_dec;
  logic [1:0]             core_mode;
  logic [255:0]           core_key;
  logic [127:0]           core_data_in, core_data_out;
  logic                   core_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_pulses = 0, rst_run = 0, run_before_start = 0, onehot_err = 0;
  logic start_prev = 1'b0;
  logic core_dead = 1'b0;

  aes_core_sched #(.NUM_REQ(NUM_REQ), .RST_CYCLES(2), .START_CYCLES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
    .req_mode(req_mode), .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .core_reset(core_reset), .core_start(core_start),
    .core_enc_dec(core_enc_dec), .core_mode(core_mode), .core_key(core_key),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_done(core_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] model(input logic enc, input logic [1:0] mode,
                                         input logic [255:0] key, input logic [127:0] din);
    if (mode == 2'd2 && key == K256 && !enc && din == PT)   return C256;
    if (mode == 2'd2 && key == K256 &&  enc && din == C256) return PT;
    if (mode == 2'd0 && key[255:128] == K128[255:128] && !enc && din == PT)   return C128;
    if (mode == 2'd0 && key[255:128] == K128[255:128] &&  enc && din == C128) return PT;
    return BAD;
  endfunction

  // Core model: done level rises a fixed delay after start, cleared by core_reset.
  logic       m_busy = 1'b0, m_done = 1'b0;
  logic [3:0] m_cnt = '0;
  logic [127:0] m_out = '0;
  always @(posedge clk) begin
    if (core_reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_out <= '0;
    end else if (core_start) begin
      m_busy <= 1'b1; m_cnt <= 4'd3;
    end else if (m_busy && !core_dead) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1; m_busy <= 1'b0;
        m_out  <= model(core_enc_dec, core_mode, core_key, core_data_in);
      end else m_cnt <= m_cnt - 1'b1;
    end
  end
  assign core_done     = m_done;
  assign core_data_out = m_out;

  // Observers: start pulses, core_reset run length before start, response exclusivity.
  always @(negedge clk) begin
    if (core_start && !start_prev) begin
      start_pulses++;
      run_before_start = rst_run;
    end
    if (core_reset) rst_run++; else rst_run = 0;
    start_prev = core_start;
    if ($countones(rsp_valid) > 1) onehot_err++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic enc, input logic [1:0] mode,
                         input logic [255:0] key, input logic [127:0] din);
    req_enc_dec[i]        = enc;
    req_mode[i*2 +: 2]    = mode;
    req_key[i*256 +: 256] = key;
    req_data[i*128 +: 128] = din;
  endtask

  // One job end to end; optionally hold the response for `hold` cycles.
  task automatic run_job(input int idx, input logic enc, input logic [1:0] mode,
                         input logic [255:0] key, input logic [127:0] din,
                         input logic [127:0] exp_d, input logic exp_e,
                         input int hold, input string tag, output int lat);
    int g_cyc;
    bit found;
    bit stable;
    lat = -1;
    @(negedge clk);
    set_req(idx, enc, mode, key, din);
    req_valid[idx] = 1'b1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready[idx]) begin found = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_grant"}, found, 1'b1);
    g_cyc = cyc;
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    found = 0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin found = 1; break; end
    end
    chk({tag, "_rsp_seen"}, found, 1'b1);
    if (found) begin
      lat = cyc - g_cyc;
      chk({tag, "_data"}, rsp_data, exp_d);
      chk({tag, "_err"}, rsp_err, exp_e);
      if (hold > 0) begin
        stable = 1;
        rsp_ready[(idx + 1) % NUM_REQ] = 1'b1;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          if (!rsp_valid[idx] || rsp_data !== exp_d || rsp_err !== exp_e) stable = 0;
        end
        rsp_ready[(idx + 1) % NUM_REQ] = 1'b0;
        chk({tag, "_hold"}, stable, 1'b1);
      end
      rsp_ready[idx] = 1'b1;
      @(negedge clk);
      chk({tag, "_released"}, rsp_valid, '0);
      rsp_ready[idx] = 1'b0;
    end
  endtask

  int lat, sp0;
  int order[$];
  logic [127:0] got_d[NUM_REQ];
  logic         got_e[NUM_REQ];
  int           n_rsp;
  logic [NUM_REQ-1:0] pend, seen;

  initial begin
    reset = 1'b0; req_valid = '0; req_enc_dec = '0; req_mode = '0;
    req_key = '0; req_data = '0; rsp_ready = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_outs", {req_ready, rsp_valid, rsp_err, core_start}, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_core_reset", core_reset, 0);

    // AES-256 encipher, requester 0; grant->rsp = 1+2+2+4(core)+1
    run_job(0, 1'b0, 2'd2, K256, PT, C256, 1'b0, 0, "enc256", lat);
    chk("enc256_lat", lat, 10);
    chk("enc256_crst_len", run_before_start, 2);
    run_job(2, 1'b1, 2'd2, K256, C256, PT, 1'b0, 0, "dec256", lat);
    run_job(1, 1'b0, 2'd0, K128, PT, C128, 1'b0, 0, "enc128", lat);

    // Reserved mode: immediate error response, core untouched
    sp0 = start_pulses;
    run_job(1, 1'b0, 2'd3, K256, PT, 128'h0, 1'b1, 0, "rsvd", lat);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_nostart", start_pulses - sp0, 0);

    // Timeout with a dead core; hold the response and poke a non-owner ready
    core_dead = 1'b1;
    run_job(3, 1'b0, 2'd2, K256, PT, 128'h0, 1'b1, 10, "tmo", lat);
    chk("tmo_lat", lat, 5 + TIMEOUT);
    core_dead = 1'b0;

    // Reset from reset: all four requesters at once
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    set_req(0, 1'b0, 2'd2, K256, PT);
    set_req(1, 1'b1, 2'd2, K256, C256);
    set_req(2, 1'b0, 2'd0, K128, PT);
    set_req(3, 1'b1, 2'd0, K128, C128);
    rsp_ready = '1;
    req_valid = '1;
    pend = '0; seen = '0; n_rsp = 0;
    for (int k = 0; k < 400 && n_rsp < NUM_REQ; k++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) order.push_back(i);
        if (rsp_valid[i] && !seen[i]) begin
          seen[i] = 1'b1; got_d[i] = rsp_data; got_e[i] = rsp_err; n_rsp++;
        end
      end
      req_valid = req_valid & ~pend;
      pend = req_ready;
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = '0;
    chk("all4_count", n_rsp, NUM_REQ);
    chk("all4_ngrants", order.size(), NUM_REQ);
    for (int i = 0; i < NUM_REQ && i < order.size(); i++)
      chk($sformatf("all4_order%0d", i), order[i], i);
    chk("all4_d0", got_d[0], C256);
    chk("all4_d1", got_d[1], PT);
    chk("all4_d2", got_d[2], C128);
    chk("all4_d3", got_d[3], PT);
    chk("all4_err", {got_e[0], got_e[1], got_e[2], got_e[3]}, '0);
    chk("onehot_rsp", onehot_err, 0);

    // Reset mid-WAIT drops the job
    core_dead = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 2'd2, K256, PT);
    req_valid[0] = 1'b1;
    sp0 = start_pulses;
    for (int k = 0; k < 50 && start_pulses == sp0; k++) @(negedge clk);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 50 && core_start; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_in_wait", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_core_reset", core_reset, 1);
    chk("mid_rsp_valid", rsp_valid, '0);
    reset = 1'b1;
    core_dead = 1'b0;
    run_job(2, 1'b0, 2'd0, K128, PT, C128, 1'b0, 0, "post_rst", lat);
    chk("onehot_final", onehot_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
